// File: rtl/qspi_flash_responder.sv
// rtl/qspi_flash_responder.sv - QSPI flash responder serving Quad I/O Fast Read (0xEB) from a byte-wide memory
// Oversamples SCK/CE_N/IO on clk and walks CMD/ADDR/MODE/DUMMY/DATA phases.
module qspi_flash_responder #(
   parameter int AW      = 24,
   parameter int DUMMY   = 4,
   parameter int CONT_EN = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sck,
   input  logic          ce_n,
   input  logic [3:0]    io_i,
   output logic [3:0]    io_o,
   output logic [3:0]    io_oe,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_IGNORE
   } state_t;

   state_t        r_state, w_state_nx;
   logic [3:0]    r_cnt, w_cnt_nx;
   logic [1:0]    r_sck_s, r_ce_s;
   logic [3:0]    r_io_s0, r_io_s1;
   logic          r_sck_d, r_ce_d;
   logic [19:0]   r_sh;
   logic [7:0]    r_data;
   logic          r_cont, r_nib, r_rd_d;
   logic [3:0]    r_io_o, r_io_oe;
   logic          r_mem_rd;
   logic [AW-1:0] r_addr;

   logic          w_rise, w_fall, w_ce_hi, w_ce_fall;
   logic [7:0]    w_cmd;
   logic [23:0]   w_sh_nib;

   assign w_rise    = r_sck_s[1] & ~r_sck_d;
   assign w_fall    = ~r_sck_s[1] & r_sck_d;
   assign w_ce_hi   = r_ce_s[1];
   assign w_ce_fall = r_ce_d & ~r_ce_s[1];
   assign w_cmd     = {r_sh[6:0], r_io_s1[0]};
   assign w_sh_nib  = {r_sh, r_io_s1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      if (w_ce_hi) begin
         w_state_nx = S_IDLE;
         w_cnt_nx   = '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_ce_fall) begin
               w_state_nx = r_cont ? S_ADDR : S_CMD;
               w_cnt_nx   = '0;
            end
            S_CMD: if (w_rise) begin
               if (r_cnt == 4'd7) begin
                  w_state_nx = (w_cmd == 8'hEB) ? S_ADDR : S_IGNORE;
                  w_cnt_nx   = '0;
               end else w_cnt_nx = r_cnt + 4'd1;
            end
            S_ADDR: if (w_rise) begin
               if (r_cnt == 4'd5) begin
                  w_state_nx = S_MODE;
                  w_cnt_nx   = '0;
               end else w_cnt_nx = r_cnt + 4'd1;
            end
            S_MODE: if (w_rise) begin
               if (r_cnt == 4'd1) begin
                  w_state_nx = S_DUMMY;
                  w_cnt_nx   = '0;
               end else w_cnt_nx = r_cnt + 4'd1;
            end
            S_DUMMY: if (w_rise) begin
               if (r_cnt == 4'(DUMMY - 1)) begin
                  w_state_nx = S_DATA;
                  w_cnt_nx   = '0;
               end else w_cnt_nx = r_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Datapath: synchronisers, shift/prefetch registers and pad outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sck_s  <= '0;
         r_sck_d  <= 1'b0;
         r_ce_s   <= 2'b11;
         r_ce_d   <= 1'b1;
         r_io_s0  <= '0;
         r_io_s1  <= '0;
         r_sh     <= '0;
         r_data   <= '0;
         r_cont   <= 1'b0;
         r_nib    <= 1'b0;
         r_rd_d   <= 1'b0;
         r_io_o   <= '0;
         r_io_oe  <= '0;
         r_mem_rd <= 1'b0;
         r_addr   <= '0;
      end else begin
         r_sck_s  <= {r_sck_s[0], sck};
         r_sck_d  <= r_sck_s[1];
         r_ce_s   <= {r_ce_s[0], ce_n};
         r_ce_d   <= r_ce_s[1];
         r_io_s0  <= io_i;
         r_io_s1  <= r_io_s0;
         r_mem_rd <= 1'b0;
         r_rd_d   <= r_mem_rd;
         if (r_rd_d) r_data <= mem_rdata;

         if (w_ce_hi) begin
            r_io_oe <= '0;
            r_nib   <= 1'b0;
         end else begin
            if (w_rise) begin
               if (r_state == S_CMD)
                  r_sh <= {r_sh[18:0], r_io_s1[0]};
               else if (r_state == S_ADDR || r_state == S_MODE)
                  r_sh <= {r_sh[15:0], r_io_s1};
            end
            if (w_rise && r_state == S_ADDR && r_cnt == 4'd5) begin
               r_addr   <= w_sh_nib[AW-1:0];
               r_mem_rd <= 1'b1;
            end
            // r_sh[3:0] holds the first mode nibble, so M[5:4] sits in r_sh[1:0]
            if (w_rise && r_state == S_MODE && r_cnt == 4'd1)
               r_cont <= (CONT_EN != 0) && (r_sh[1:0] == 2'b10);
            if (w_fall && r_state == S_DATA) begin
               r_io_oe <= 4'hF;
               r_nib   <= ~r_nib;
               if (!r_nib) begin
                  r_io_o <= r_data[7:4];
               end else begin
                  r_io_o   <= r_data[3:0];
                  r_mem_rd <= 1'b1;
                  r_addr   <= r_addr + 1'b1;
               end
            end
         end
      end
   end

   assign io_o     = r_io_o;
   assign io_oe    = r_io_oe;
   assign mem_rd   = r_mem_rd;
   assign mem_addr = r_addr;

endmodule
